star_bank: RTL and testbench

//  Parametrised manager for N collectible stars; generalises the single-star block.
//  - Holds world positions for all stars and keeps a per-star enable mask.
//  - Time-multiplexes one overlap comparator across the stars, one star per cycle.
//  - Produces a registered touch pulse, a saturating collected-star count and an

---
 rtl/star_bank.sv | 209 ++++++++++++++++++++
 tb/tb_star_bank.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_bank.sv
// -----------------------------------------------------------------------------
// star_bank
// Manager for N_STARS collectible stars. Holds fixed world positions, a
// per-star enable mask, and scans one star per cycle against a snapshot of the
// character position taken once per sweep. Collections raise a one-cycle
// touch_pulse, bump a saturating score and optionally re-enable the star after
// RESPAWN_CYC cycles. A combinational read port serves the sprite renderer.
//
// Ports
//   sys_clk       : clock, all state on rising edge
//   RST           : synchronous active-high reset
//   level_clr     : synchronous restart (re-enable all, zero score, keep ptr)
//   char_X/char_Y : character world position (top-left)
//   bg_pos        : background scroll offset
//   rd_idx        : renderer star select
//   rd_x/rd_y     : star screen X (world X - bg_pos, mod 1024) / star Y
//   rd_en         : star present flag for rd_idx (0 when rd_idx >= N_STARS)
//   en_mask       : per-star present flags
//   touch_pulse   : one-cycle collection pulse
//   touch_idx     : index of the last collected star
//   score         : saturating collected count
//   all_collected : registered (en_mask == 0)
// -----------------------------------------------------------------------------
module star_bank #(
    parameter int unsigned           N_STARS     = 8,
    parameter int unsigned           STAR_W      = 12,
    parameter int unsigned           STAR_H      = 12,
    parameter int unsigned           CHAR_W      = 12,
    parameter int unsigned           CHAR_H      = 12,
    parameter logic [10*N_STARS-1:0] X_INIT      = '0,
    parameter logic [10*N_STARS-1:0] Y_INIT      = '0,
    parameter int unsigned           RESPAWN_CYC = 0,
    parameter int unsigned           SCORE_W     = 8,
    localparam int unsigned          IW          = (N_STARS > 1) ? $clog2(N_STARS) : 1
) (
    input  logic               sys_clk,
    input  logic               RST,
    input  logic               level_clr,
    input  logic [9:0]         char_X,
    input  logic [9:0]         char_Y,
    input  logic [9:0]         bg_pos,
    input  logic [IW-1:0]      rd_idx,
    output logic [9:0]         rd_x,
    output logic [9:0]         rd_y,
    output logic               rd_en,
    output logic [N_STARS-1:0] en_mask,
    output logic               touch_pulse,
    output logic [IW-1:0]      touch_idx,
    output logic [SCORE_W-1:0] score,
    output logic               all_collected
);

    // Position tables padded to a power of two so any rd_idx/ptr value indexes
    // a defined entry; padding entries read as zero / not present.
    localparam int unsigned NTAB = 1 << IW;

    logic [9:0] tab_x  [NTAB];
    logic [9:0] tab_y  [NTAB];
    logic       tab_en [NTAB];

    for (genvar g = 0; g < NTAB; g++) begin : g_tab
        if (g < N_STARS) begin : g_real
            assign tab_x[g]  = X_INIT[10*g +: 10];
            assign tab_y[g]  = Y_INIT[10*g +: 10];
            assign tab_en[g] = en_mask[g];
        end else begin : g_pad
            assign tab_x[g]  = '0;
            assign tab_y[g]  = '0;
            assign tab_en[g] = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    always_comb begin
        rd_x  = '0;
        rd_y  = '0;
        rd_en = 1'b0;
        if (32'(rd_idx) < N_STARS) begin
            rd_x  = tab_x[rd_idx] - bg_pos;
            rd_y  = tab_y[rd_idx];
            rd_en = tab_en[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Scan pointer, snapshot and overlap comparator
    // ------------------------------------------------------------------
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      ptr_next;
    logic               ptr_last;
    logic [9:0]         snap_X;
    logic [9:0]         snap_Y;
    logic               snap_valid;
    logic [10:0]        star_x11;
    logic [10:0]        star_y11;
    logic [10:0]        snap_x11;
    logic [10:0]        snap_y11;
    logic               hit;
    logic               collect;
    logic [N_STARS-1:0] collect_oh;
    logic [N_STARS-1:0] respawn;
    logic [N_STARS-1:0] en_next;

    assign ptr_last = (ptr == IW'(N_STARS - 1));
    assign ptr_next = ptr_last ? '0 : ptr + 1'b1;

    always_comb begin
        star_x11 = {1'b0, tab_x[ptr]};
        star_y11 = {1'b0, tab_y[ptr]};
        snap_x11 = {1'b0, snap_X};
        snap_y11 = {1'b0, snap_Y};
        // 11-bit sums: boxes near the right/bottom edge must not wrap.
        hit = (snap_x11 <= star_x11 + 11'(STAR_W)) &&
              (snap_x11 + 11'(CHAR_W) >= star_x11) &&
              (snap_y11 <= star_y11 + 11'(STAR_H)) &&
              (snap_y11 + 11'(CHAR_H) >= star_y11);
        collect = hit && snap_valid && tab_en[ptr];
    end

    always_comb begin
        collect_oh = '0;
        for (int unsigned i = 0; i < N_STARS; i++) begin
            collect_oh[i] = collect && (ptr == IW'(i));
        end
    end

    // Hit and respawn never touch the same star in one cycle: a hit needs the
    // star enabled, a respawn needs it disabled.
    always_comb begin
        en_next = (en_mask | respawn) & ~collect_oh;
    end

    // ------------------------------------------------------------------
    // Respawn counters
    // ------------------------------------------------------------------
    if (RESPAWN_CYC > 0) begin : g_resp
        localparam int unsigned CW = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

        logic [CW-1:0] resp_cnt [N_STARS];

        always_comb begin
            respawn = '0;
            for (int unsigned i = 0; i < N_STARS; i++) begin
                respawn[i] = !en_mask[i] && (resp_cnt[i] == CW'(RESPAWN_CYC - 1));
            end
        end

        always_ff @(posedge sys_clk) begin
            for (int unsigned i = 0; i < N_STARS; i++) begin
                if (RST || level_clr) begin
                    resp_cnt[i] <= '0;
                end else if (collect_oh[i] || respawn[i]) begin
                    resp_cnt[i] <= '0;
                end else if (!en_mask[i]) begin
                    resp_cnt[i] <= resp_cnt[i] + 1'b1;
                end
            end
        end
    end else begin : g_no_resp
        assign respawn = '0;
    end

    // ------------------------------------------------------------------
    // Main state
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (RST) begin
            ptr           <= '0;
            en_mask       <= '1;
            score         <= '0;
            touch_pulse   <= 1'b0;
            touch_idx     <= '0;
            all_collected <= 1'b0;
            snap_valid    <= 1'b0;
            snap_X        <= '0;
            snap_Y        <= '0;
        end else begin
            // The scan keeps running through level_clr; only the game state
            // restarts, and the snapshot is invalidated until the next sweep.
            ptr <= ptr_next;
            if (level_clr) begin
                en_mask       <= '1;
                score         <= '0;
                touch_pulse   <= 1'b0;
                touch_idx     <= '0;
                all_collected <= 1'b0;
                snap_valid    <= 1'b0;
            end else begin
                en_mask       <= en_next;
                all_collected <= (en_next == '0);
                touch_pulse   <= collect;
                if (collect) begin
                    touch_idx <= ptr;
                    if (score != '1) begin
                        score <= score + 1'b1;
                    end
                end
                if (ptr_last) begin
                    snap_X     <= char_X;
                    snap_Y     <= char_Y;
                    snap_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_star_bank.sv
module tb_star_bank;

    localparam int NA = 4;
    localparam int NB = 5;
    localparam int RB = 50;

    localparam logic [39:0] AX = {10'd900, 10'd300, 10'd200, 10'd100};
    localparam logic [39:0] AY = {4{10'd306}};
    localparam logic [49:0] BX = {10'd500, 10'd900, 10'd300, 10'd200, 10'd100};
    localparam logic [49:0] BY = {5{10'd306}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       RST, level_clr;
    logic [9:0] bg_pos;
    logic [9:0] a_cx, a_cy, b_cx, b_cy;
    logic [1:0] a_ri;
    logic [2:0] b_ri;

    logic [9:0] a_rx, a_ry, b_rx, b_ry;
    logic       a_re, b_re, a_tp, b_tp, a_ac, b_ac;
    logic [3:0] a_en;
    logic [4:0] b_en;
    logic [1:0] a_ti;
    logic [2:0] b_ti;
    logic [7:0] a_sc;
    logic [1:0] b_sc;

    star_bank #(.N_STARS(NA), .X_INIT(AX), .Y_INIT(AY), .RESPAWN_CYC(0), .SCORE_W(8)) dut_a (
        .sys_clk(clk), .RST(RST), .level_clr(level_clr),
        .char_X(a_cx), .char_Y(a_cy), .bg_pos(bg_pos), .rd_idx(a_ri),
        .rd_x(a_rx), .rd_y(a_ry), .rd_en(a_re), .en_mask(a_en),
        .touch_pulse(a_tp), .touch_idx(a_ti), .score(a_sc), .all_collected(a_ac));

    star_bank #(.N_STARS(NB), .X_INIT(BX), .Y_INIT(BY), .RESPAWN_CYC(RB), .SCORE_W(2)) dut_b (
        .sys_clk(clk), .RST(RST), .level_clr(level_clr),
        .char_X(b_cx), .char_Y(b_cy), .bg_pos(bg_pos), .rd_idx(b_ri),
        .rd_x(b_rx), .rd_y(b_ry), .rd_en(b_re), .en_mask(b_en),
        .touch_pulse(b_tp), .touch_idx(b_ti), .score(b_sc), .all_collected(b_ac));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_n[2]    = '{NA, NB};
    int  m_r[2]    = '{0, RB};
    int  m_smax[2] = '{255, 3};
    int  sx[2][5];
    int  sy[2][5];
    bit  m_live[2];
    int  m_edge[2], m_ptr[2], m_score[2], m_idx[2], m_snx[2], m_sny[2];
    bit  m_valid[2], m_pulse[2], m_allc[2];
    bit  m_en[2][5];
    int  m_back[2][5];

    function automatic bit overlap(int cx, int cy, int x, int y);
        return (cx <= x + 12) && (cx + 12 >= x) && (cy <= y + 12) && (cy + 12 >= y);
    endfunction

    task automatic model_restart(input int k);
        for (int i = 0; i < 5; i++) m_en[k][i] = 1'b1;
        m_score[k] = 0; m_pulse[k] = 0; m_idx[k] = 0;
        m_valid[k] = 0; m_allc[k] = 0;
    endtask

    task automatic model_step(input int k, input int cx, input int cy);
        int  p;
        bit  got;
        bit  any;
        p = m_ptr[k];
        if (RST) begin
            model_restart(k);
            m_ptr[k]  = 0;
            m_live[k] = 1'b1;
        end else if (level_clr) begin
            model_restart(k);
            m_ptr[k] = (p + 1) % m_n[k];
        end else begin
            got = m_valid[k] && m_en[k][p] && overlap(m_snx[k], m_sny[k], sx[k][p], sy[k][p]);
            for (int i = 0; i < m_n[k]; i++)
                if (m_r[k] > 0 && !m_en[k][i] && m_edge[k] == m_back[k][i]) m_en[k][i] = 1'b1;
            m_pulse[k] = got;
            if (got) begin
                m_en[k][p]   = 1'b0;
                m_back[k][p] = m_edge[k] + m_r[k];
                m_idx[k]     = p;
                if (m_score[k] < m_smax[k]) m_score[k]++;
            end
            if (p == m_n[k] - 1) begin
                m_snx[k] = cx; m_sny[k] = cy; m_valid[k] = 1'b1;
            end
            any = 0;
            for (int i = 0; i < m_n[k]; i++) any |= m_en[k][i];
            m_allc[k] = !any;
            m_ptr[k]  = (p + 1) % m_n[k];
        end
        m_edge[k]++;
    endtask

    function automatic int exp_mask(input int k);
        int v = 0;
        for (int i = 0; i < m_n[k]; i++) if (m_en[k][i]) v |= (1 << i);
        return v;
    endfunction

    function automatic int exp_rdx(input int k, input int idx);
        return (idx < m_n[k]) ? ((sx[k][idx] - int'(bg_pos)) & 1023) : 0;
    endfunction

    function automatic int exp_rdy(input int k, input int idx);
        return (idx < m_n[k]) ? sy[k][idx] : 0;
    endfunction

    function automatic int exp_rden(input int k, input int idx);
        return (idx < m_n[k]) ? int'(m_en[k][idx]) : 0;
    endfunction

    always @(posedge clk) begin
        model_step(0, int'(a_cx), int'(a_cy));
        model_step(1, int'(b_cx), int'(b_cy));
    end

    always @(negedge clk) begin
        if (m_live[0]) begin
            check("A.pulse", a_tp, m_pulse[0]);
            check("A.idx",   a_ti, m_idx[0]);
            check("A.mask",  a_en, exp_mask(0));
            check("A.score", a_sc, m_score[0]);
            check("A.allc",  a_ac, m_allc[0]);
            check("A.rd_x",  a_rx, exp_rdx(0, a_ri));
            check("A.rd_y",  a_ry, exp_rdy(0, a_ri));
            check("A.rd_en", a_re, exp_rden(0, a_ri));
        end
        if (m_live[1]) begin
            check("B.pulse", b_tp, m_pulse[1]);
            check("B.idx",   b_ti, m_idx[1]);
            check("B.mask",  b_en, exp_mask(1));
            check("B.score", b_sc, m_score[1]);
            check("B.allc",  b_ac, m_allc[1]);
            check("B.rd_x",  b_rx, exp_rdx(1, b_ri));
            check("B.rd_y",  b_ry, exp_rdy(1, b_ri));
            check("B.rd_en", b_re, exp_rden(1, b_ri));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int k, input int lim, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < lim; i++) begin
            cyc();
            if ((k == 0) ? a_tp : b_tp) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        level_clr = 1'b1;
        cyc();
        level_clr = 1'b0;
    endtask

    initial begin
        bit seen;
        int cnt;
        int s;

        sx[0] = '{100, 200, 300, 900, 0};
        sy[0] = '{306, 306, 306, 306, 0};
        sx[1] = '{100, 200, 300, 900, 500};
        sy[1] = '{306, 306, 306, 306, 306};

        RST = 1'b1; level_clr = 1'b0; bg_pos = '0;
        a_cx = 10'd95; a_cy = 10'd300; b_cx = '0; b_cy = '0;
        a_ri = '0; b_ri = '0;
        repeat (3) cyc();
        RST = 1'b0;

        // Reset state and the blind first sweep
        cyc();
        check("rst.mask", a_en, 4'hF);
        check("rst.score", a_sc, 0);
        check("rst.allc", a_ac, 0);
        check("rst.nopulse0", a_tp, 0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            check("rst.nopulse", a_tp, 0);
        end

        // Basic hit, then no repeat while holding
        wait_pulse(0, 3 * NA + 4, seen);
        check("hit.seen", seen, 1);
        check("hit.idx", a_ti, 0);
        check("hit.mask", a_en, 4'hE);
        check("hit.score", a_sc, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            cnt += a_tp;
        end
        check("hit.norepeat", cnt, 0);

        // Inclusive edge and one-pixel miss
        pulse_clr();
        check("clr.mask", a_en, 4'hF);
        check("clr.score", a_sc, 0);
        a_cx = 10'd88; a_cy = 10'd306;
        wait_pulse(0, 3 * NA + 4, seen);
        check("edge.seen", seen, 1);
        check("edge.idx", a_ti, 0);
        pulse_clr();
        a_cx = 10'd87;
        wait_pulse(0, 3 * NA + 4, seen);
        check("miss.seen", seen, 0);

        // Full sweep to all_collected, then level_clr
        pulse_clr();
        a_cx = 10'd100;
        wait_pulse(0, 3 * NA + 4, seen); check("sweep.s0", seen, 1);
        a_cx = 10'd200;
        wait_pulse(0, 3 * NA + 4, seen); check("sweep.s1", seen, 1);
        a_cx = 10'd300;
        wait_pulse(0, 3 * NA + 4, seen); check("sweep.s2", seen, 1);
        check("sweep.allc_early", a_ac, 0);
        a_cx = 10'd900;
        wait_pulse(0, 3 * NA + 4, seen);
        check("sweep.s3", seen, 1);
        check("sweep.idx", a_ti, 3);
        check("sweep.mask", a_en, 0);
        check("sweep.allc", a_ac, 1);
        check("sweep.score", a_sc, 4);
        pulse_clr();
        check("sweep.clr_mask", a_en, 4'hF);
        check("sweep.clr_score", a_sc, 0);
        check("sweep.clr_allc", a_ac, 0);

        // Respawn timing on the B instance
        b_ri = 3'd1; b_cx = 10'd195; b_cy = 10'd300;
        wait_pulse(1, 3 * NB + 4, seen);
        check("resp.seen1", seen, 1);
        check("resp.idx1", b_ti, 1);
        check("resp.score1", b_sc, 1);
        check("resp.gone", b_re, 0);
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (b_re) break;
            cnt++;
        end
        check("resp.low_cycles", cnt, RB);
        wait_pulse(1, 3 * NB + 4, seen);
        check("resp.seen2", seen, 1);
        check("resp.idx2", b_ti, 1);
        check("resp.score2", b_sc, 2);

        // Saturation after five collections
        for (int i = 0; i < 3; i++) begin
            wait_pulse(1, RB + 3 * NB + 4, seen);
            check("sat.seen", seen, 1);
        end
        check("sat.score", b_sc, 3);

        // Read port wrap and out-of-range select
        bg_pos = 10'd950; a_ri = 2'd0; b_ri = 3'd0;
        #1;
        check("rd.a_x0", a_rx, 174);
        check("rd.b_x0", b_rx, 174);
        b_ri = 3'd4;
        #1;
        check("rd.b_x4", b_rx, 574);
        check("rd.b_y4", b_ry, 306);
        b_ri = 3'd5;
        #1;
        check("rd.oor_en", b_re, 0);
        check("rd.oor_x", b_rx, 0);
        check("rd.oor_y", b_ry, 0);

        // Randomised phase against the model
        for (int it = 0; it < 3000; it++) begin
            level_clr = ($urandom_range(0, 39) == 0);
            RST       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 5) == 0) begin
                    a_cx = 10'($urandom_range(0, 1023));
                    a_cy = 10'($urandom_range(0, 1023));
                end else begin
                    s    = $urandom_range(0, NA - 1);
                    a_cx = 10'(sx[0][s] + $urandom_range(0, 32) - 16);
                    a_cy = 10'(306 + $urandom_range(0, 32) - 16);
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                s    = $urandom_range(0, NB - 1);
                b_cx = 10'(sx[1][s] + $urandom_range(0, 32) - 16);
                b_cy = 10'(306 + $urandom_range(0, 32) - 16);
            end
            bg_pos = 10'($urandom);
            a_ri   = 2'($urandom);
            b_ri   = 3'($urandom);
            cyc();
        end
        RST = 1'b0;
        level_clr = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
